// File: rtl/button_debouncer.sv
// button_debouncer
//   Multi-channel push-button conditioning on the 50 MHz board clock. Each
//   channel is synchronised, debounced with a stability counter, and turned
//   into a clean level plus one-cycle press, release and long-press pulses.
//
// Parameters
//   NUM_BUTTONS       number of independent channels (>= 1)
//   DEBOUNCE_CYCLES   consecutive stable samples needed to accept a new level (>= 1)
//   LONG_PRESS_CYCLES cycles held before btn_long fires; 0 disables long-press
//   ACTIVE_LOW        1 = raw pin reads 0 when pressed
//
// Ports
//   clk_50MHz    in   board clock
//   rst          in   synchronous active-high reset
//   buttons      in   raw asynchronous button pins
//   btn_level    out  debounced state, 1 = pressed
//   btn_press    out  one-cycle pulse on debounced 0->1
//   btn_release  out  one-cycle pulse on debounced 1->0
//   btn_long     out  one-cycle pulse, at most once per press
module button_debouncer #(
  parameter int NUM_BUTTONS       = 2,
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 50_000_000,
  parameter bit ACTIVE_LOW        = 1'b0
) (
  input  logic                   clk_50MHz,
  input  logic                   rst,
  input  logic [NUM_BUTTONS-1:0] buttons,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_press,
  output logic [NUM_BUTTONS-1:0] btn_release,
  output logic [NUM_BUTTONS-1:0] btn_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  // A zero-width hold counter is not legal, so keep one bit when disabled.
  localparam int HW = (LONG_PRESS_CYCLES > 0) ? $clog2(LONG_PRESS_CYCLES + 1) : 1;

  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HSAT  = HW'(LONG_PRESS_CYCLES);
  localparam logic [HW-1:0] HPRE  = HW'(LONG_PRESS_CYCLES - 1);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_ch
    logic          sync1_q, sync2_q;
    logic          s;
    logic [DW-1:0] dcnt_q, dcnt_d;
    logic [HW-1:0] hcnt_q, hcnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          long_q, long_d;

    // Sample in "pressed = 1" polarity regardless of board wiring.
    assign s = sync2_q ^ ACTIVE_LOW;

    always_comb begin
      dcnt_d  = '0;
      level_d = level_q;
      press_d = 1'b0;
      rel_d   = 1'b0;
      // Any agreeing sample drops dcnt back to 0, so the count only
      // completes after an unbroken run of disagreeing samples.
      if (s != level_q) begin
        if (dcnt_q == DLAST) begin
          level_d = s;
          press_d = s;
          rel_d   = ~s;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
    end

    always_comb begin
      hcnt_d = '0;
      long_d = 1'b0;
      if (LONG_PRESS_CYCLES > 0 && level_q) begin
        // Saturating at HSAT means HPRE is passed only once per press.
        hcnt_d = (hcnt_q == HSAT) ? hcnt_q : hcnt_q + 1'b1;
        long_d = (hcnt_q == HPRE);
      end
    end

    always_ff @(posedge clk_50MHz) begin
      if (rst) begin
        // Synchroniser loads the released pin value so a held button is
        // seen as a fresh press once reset lifts.
        sync1_q <= ACTIVE_LOW;
        sync2_q <= ACTIVE_LOW;
        dcnt_q  <= '0;
        hcnt_q  <= '0;
        level_q <= 1'b0;
        press_q <= 1'b0;
        rel_q   <= 1'b0;
        long_q  <= 1'b0;
      end else begin
        sync1_q <= buttons[i];
        sync2_q <= sync1_q;
        dcnt_q  <= dcnt_d;
        hcnt_q  <= hcnt_d;
        level_q <= level_d;
        press_q <= press_d;
        rel_q   <= rel_d;
        long_q  <= long_d;
      end
    end

    assign btn_level[i]   = level_q;
    assign btn_press[i]   = press_q;
    assign btn_release[i] = rel_q;
    assign btn_long[i]    = long_q;
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Bench for button_debouncer: two instances (ACTIVE_LOW=0 and ACTIVE_LOW=1)
// driven with complementary pins, so every scenario covers both polarities.
module tb_button_debouncer;
  localparam int NB = 2;
  localparam int DC = 4;
  localparam int LP = 10;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic          rst;
  logic [NB-1:0] btn;
  logic [NB-1:0] btn_n;
  assign btn_n = ~btn;

  logic [NB-1:0] lvl [2];
  logic [NB-1:0] prs [2];
  logic [NB-1:0] rls [2];
  logic [NB-1:0] lng [2];

  button_debouncer #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DC), .LONG_PRESS_CYCLES(LP),
                     .ACTIVE_LOW(1'b0)) dut_a (
    .clk_50MHz(clk), .rst(rst), .buttons(btn),
    .btn_level(lvl[0]), .btn_press(prs[0]), .btn_release(rls[0]), .btn_long(lng[0]));

  button_debouncer #(.NUM_BUTTONS(NB), .DEBOUNCE_CYCLES(DC), .LONG_PRESS_CYCLES(LP),
                     .ACTIVE_LOW(1'b1)) dut_b (
    .clk_50MHz(clk), .rst(rst), .buttons(btn_n),
    .btn_level(lvl[1]), .btn_press(prs[1]), .btn_release(rls[1]), .btn_long(lng[1]));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: counts and last cycle of each pulse per dut/channel.
  // Counts are cleared whenever the stimulus side bumps gen.
  int gen = 0;
  int last_gen = 0;
  int pc [2][NB], pcy [2][NB];
  int rc [2][NB], rcy [2][NB];
  int lc [2][NB], lcy [2][NB];
  int viol = 0;

  always @(negedge clk) begin
    if (gen != last_gen) begin
      last_gen = gen;
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < NB; i++) begin
          pc[d][i] = 0; rc[d][i] = 0; lc[d][i] = 0;
          pcy[d][i] = -1; rcy[d][i] = -1; lcy[d][i] = -1;
        end
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NB; i++) begin
        if (prs[d][i] === 1'b1) begin pc[d][i]++; pcy[d][i] = cyc; end
        if (rls[d][i] === 1'b1) begin rc[d][i]++; rcy[d][i] = cyc; end
        if (lng[d][i] === 1'b1) begin lc[d][i]++; lcy[d][i] = cyc; end
        if (prs[d][i] === 1'b1 && (rls[d][i] === 1'b1 || lng[d][i] === 1'b1)) viol++;
      end
  end

  int errors = 0;
  int checks = 0;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = '0;
    tick(3);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({lvl[d], prs[d], rls[d], lng[d]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs dut%0d got %b want 0", d, {lvl[d], prs[d], rls[d], lng[d]});
      end
    end
    gen++;
    rst = 1'b0;
    tick(12);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pc[d][0] + pc[d][1] + rc[d][0] + rc[d][1] + lc[d][0] + lc[d][1] !== 0 || lvl[d] !== '0) begin
        errors++;
        $display("FAIL idle_after_reset dut%0d got pulses=%0d level=%b want 0/00", d,
                 pc[d][0] + pc[d][1] + rc[d][0] + rc[d][1] + lc[d][0] + lc[d][1], lvl[d]);
      end
    end
  endtask

  task automatic test_clean_press();
    int t0, tr;
    gen++;
    btn[0] = 1'b1;
    t0 = cyc + 1;
    tick(20);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pc[d][0] !== 1 || pcy[d][0] - t0 !== DC + 1) begin
        errors++;
        $display("FAIL clean_press dut%0d got count=%0d delay=%0d want 1/%0d", d, pc[d][0], pcy[d][0] - t0, DC + 1);
      end
      checks++;
      if (lvl[d][0] !== 1'b1) begin
        errors++;
        $display("FAIL clean_level dut%0d got %b want 1", d, lvl[d][0]);
      end
      checks++;
      if (pc[d][1] + rc[d][1] + lc[d][1] !== 0 || lvl[d][1] !== 1'b0) begin
        errors++;
        $display("FAIL ch1_quiet dut%0d got pulses=%0d level=%b want 0/0", d, pc[d][1] + rc[d][1] + lc[d][1], lvl[d][1]);
      end
    end
    btn[0] = 1'b0;
    tr = cyc + 1;
    tick(20);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rc[d][0] !== 1 || rcy[d][0] - tr !== DC + 1 || lvl[d][0] !== 1'b0) begin
        errors++;
        $display("FAIL clean_release dut%0d got count=%0d delay=%0d level=%b want 1/%0d/0", d,
                 rc[d][0], rcy[d][0] - tr, lvl[d][0], DC + 1);
      end
    end
  endtask

  task automatic test_bounce();
    int t0;
    int pat [10] = '{1, 0, 1, 1, 0, 1, 1, 1, 1, 1};
    gen++;
    t0 = cyc + 1;
    for (int k = 0; k < 10; k++) begin
      btn[0] = pat[k][0];
      tick(1);
    end
    tick(10);
    // Last 0 sampled at t0+4; stable run starts at t0+5, accepted DC+1 later.
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pc[d][0] !== 1 || pcy[d][0] - t0 !== 10) begin
        errors++;
        $display("FAIL bounce_press dut%0d got count=%0d delay=%0d want 1/10", d, pc[d][0], pcy[d][0] - t0);
      end
    end
    btn[0] = 1'b0;
    tick(20);
  endtask

  task automatic test_glitch();
    gen++;
    btn[1] = 1'b1;
    tick(3);
    btn[1] = 1'b0;
    tick(15);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pc[d][1] + rc[d][1] + lc[d][1] + pc[d][0] !== 0 || lvl[d] !== '0) begin
        errors++;
        $display("FAIL glitch dut%0d got pulses=%0d level=%b want 0/00", d,
                 pc[d][1] + rc[d][1] + lc[d][1] + pc[d][0], lvl[d]);
      end
    end
  endtask

  task automatic test_long_press();
    int t0, tr;
    gen++;
    btn[0] = 1'b1;
    t0 = cyc + 1;
    tick(30);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pc[d][0] !== 1 || pcy[d][0] - t0 !== DC + 1) begin
        errors++;
        $display("FAIL long_press_edge dut%0d got count=%0d delay=%0d want 1/%0d", d, pc[d][0], pcy[d][0] - t0, DC + 1);
      end
      checks++;
      if (lc[d][0] !== 1 || lcy[d][0] - pcy[d][0] !== LP) begin
        errors++;
        $display("FAIL long_pulse dut%0d got count=%0d delay=%0d want 1/%0d", d, lc[d][0], lcy[d][0] - pcy[d][0], LP);
      end
    end
    btn[0] = 1'b0;
    tr = cyc + 1;
    tick(20);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (rc[d][0] !== 1 || rcy[d][0] - tr !== DC + 1 || lc[d][0] !== 1) begin
        errors++;
        $display("FAIL long_release dut%0d got count=%0d delay=%0d longs=%0d want 1/%0d/1", d,
                 rc[d][0], rcy[d][0] - tr, lc[d][0], DC + 1);
      end
    end
  endtask

  task automatic test_short_press();
    // 9 sampled cycles: level is high for 9 cycles, one short of LP.
    gen++;
    btn[0] = 1'b1;
    tick(9);
    btn[0] = 1'b0;
    tick(20);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pc[d][0] !== 1 || rc[d][0] !== 1 || lc[d][0] !== 0) begin
        errors++;
        $display("FAIL short_press dut%0d got p/r/l=%0d/%0d/%0d want 1/1/0", d, pc[d][0], rc[d][0], lc[d][0]);
      end
    end
    // 10 sampled cycles: level falls in the very cycle long fires.
    gen++;
    btn[0] = 1'b1;
    tick(10);
    btn[0] = 1'b0;
    tick(20);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (lc[d][0] !== 1 || lcy[d][0] - pcy[d][0] !== LP || rc[d][0] !== 1) begin
        errors++;
        $display("FAIL boundary_long dut%0d got longs=%0d delay=%0d rel=%0d want 1/%0d/1", d,
                 lc[d][0], lcy[d][0] - pcy[d][0], rc[d][0], LP);
      end
    end
  endtask

  task automatic test_reset_mid_hold();
    int trs;
    gen++;
    btn[0] = 1'b1;
    tick(10);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pc[d][0] !== 1 || lc[d][0] !== 0) begin
        errors++;
        $display("FAIL pre_reset_press dut%0d got press=%0d long=%0d want 1/0", d, pc[d][0], lc[d][0]);
      end
    end
    rst = 1'b1;
    tick(1);
    trs = cyc;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if ({lvl[d], prs[d], rls[d], lng[d]} !== '0) begin
        errors++;
        $display("FAIL mid_hold_reset dut%0d got %b want 0", d, {lvl[d], prs[d], rls[d], lng[d]});
      end
    end
    gen++;
    rst = 1'b0;
    tick(20);
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pc[d][0] !== 1 || pcy[d][0] - trs !== DC + 2 || rc[d][0] !== 0) begin
        errors++;
        $display("FAIL repress_after_reset dut%0d got count=%0d delay=%0d rel=%0d want 1/%0d/0", d,
                 pc[d][0], pcy[d][0] - trs, rc[d][0], DC + 2);
      end
      checks++;
      if (lc[d][0] !== 1 || lcy[d][0] - pcy[d][0] !== LP) begin
        errors++;
        $display("FAIL long_after_reset dut%0d got count=%0d delay=%0d want 1/%0d", d, lc[d][0], lcy[d][0] - pcy[d][0], LP);
      end
    end
    btn[0] = 1'b0;
    tick(20);
  endtask

  task automatic test_exclusive_pulses();
    checks++;
    if (viol !== 0) begin
      errors++;
      $display("FAIL exclusive_pulses got %0d overlaps want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_long_press();
    test_short_press();
    test_reset_mid_hold();
    test_exclusive_pulses();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
